// File: rtl/matmul_result_drain.sv
// Streams a rows*cols result matrix out of result SRAM in row-major order with optional ReLU.
// First word appears 2 cycles after start; reads stall when buffer credits run out, outputs hold under backpressure.
module matmul_result_drain #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [15:0]       num_rows,
    input  logic [15:0]       num_cols,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              relu_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    input  logic [DATA_W-1:0] sram_rd_data,
    output logic              sram_rd_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [31:0]         total, issued, start_total;
    logic                relu_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                rd_pending, rd_last_pending;
    logic [DATA_W-1:0]   buf_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] buf_last;
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [CNT_W:0]      credit_used;
    logic                start_hs, issue, pop;
    logic [DATA_W-1:0]   push_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign start_total = 32'(num_rows) * 32'(num_cols);
    assign start_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign start_hs    = start_valid && start_ready;

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
    assign out_last  = out_valid && buf_last[rd_ptr];
    assign pop       = out_valid && out_ready;

    // A pop this cycle frees its slot in time for the read issued now, which keeps depth 2 at full rate.
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, rd_pending} - {{CNT_W{1'b0}}, pop};
    assign issue       = (state == DRAIN) && (issued < total) &&
                         (credit_used < (CNT_W + 1)'(BUF_DEPTH));
    assign sram_rd_en   = issue;
    assign sram_rd_addr = addr_q;

    assign push_data = (relu_q && sram_rd_data[DATA_W-1]) ? '0 : sram_rd_data;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_hs) state_nxt = (start_total == 32'd0) ? DONE : DRAIN;
            DRAIN:   if (pop && out_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= IDLE;
            total           <= '0;
            issued          <= '0;
            relu_q          <= 1'b0;
            addr_q          <= '0;
            rd_pending      <= 1'b0;
            rd_last_pending <= 1'b0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            buf_last        <= '0;
        end else begin
            state           <= state_nxt;
            rd_pending      <= issue;
            rd_last_pending <= issue && (issued == total - 32'd1);
            if (start_hs) begin
                total  <= start_total;
                issued <= '0;
                relu_q <= relu_en;
                addr_q <= base_addr;
            end
            if (issue) begin
                issued <= issued + 32'd1;
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (rd_pending) begin
                buf_last[wr_ptr] <= rd_last_pending;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({rd_pending, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: out_data is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (rd_pending) buf_data[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_matmul_result_drain.sv
module tb_matmul_result_drain;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] num_rows, num_cols;
    logic [15:0] base_addr;
    logic        relu_en;
    logic [15:0] sram_rd_addr;
    logic [31:0] sram_rd_data;
    logic        sram_rd_en;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;
    logic        busy, done;

    matmul_result_drain #(.ADDR_W(16), .DATA_W(32), .BUF_DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .num_rows(num_rows), .num_cols(num_cols), .base_addr(base_addr), .relu_en(relu_en),
        .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data), .sram_rd_en(sram_rd_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];
    always @(posedge clk) if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q [$];
    logic [15:0] rd_addrs [$];
    int          reads_seen, rx_count, outstanding;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop, stall stability and outstanding-read bound.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall  = 1'b0;
            outstanding = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, prev_data);
                check("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (sram_rd_en) begin
                reads_seen++;
                rd_addrs.push_back(sram_rd_addr);
            end
            outstanding = outstanding + int'(sram_rd_en) - int'(out_valid && out_ready);
            if (sram_rd_en) check("outstanding_le2", 32'(outstanding <= 2), 32'd1);
            if (out_valid && out_ready) begin
                check("unexpected_word", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("out_data", out_data, e[31:0]);
                    check("out_last", 32'(out_last), 32'(e[32]));
                end
                rx_count++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        check({tag, "_rd_en"}, 32'(sram_rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(sram_rd_addr), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic push_expect(input int rows, input int cols, input logic [15:0] base, input logic relu);
        int total;
        total = rows * cols;
        for (int i = 0; i < total; i++) begin
            logic [31:0] w;
            logic [15:0] a;
            a = base + 16'(i);
            w = mem[a];
            if (relu && w[31]) w = 32'h0;
            exp_q.push_back({(i == total - 1), w});
        end
        reads_seen = 0;
        rx_count   = 0;
        rd_addrs.delete();
    endtask

    task automatic do_start(input int rows, input int cols, input logic [15:0] base, input logic relu);
        @(negedge clk);
        start_valid = 1'b1;
        num_rows    = 16'(rows);
        num_cols    = 16'(cols);
        base_addr   = base;
        relu_en     = relu;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
    endtask

    task automatic run_drain(input string tag, input int rows, input int cols, input logic [15:0] base,
                             input logic relu, input bit stall, input int exp_cycles);
        int cyc;
        int total;
        total = rows * cols;
        push_expect(rows, cols, base, relu);
        @(negedge clk);
        check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        do_start(rows, cols, base, relu);
        cyc = 0;
        out_ready = 1'b1;
        while (cyc < 400) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk);
            #1;
            cyc++;
            out_ready = stall ? (cyc % 3 == 0) : 1'b1;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        if (exp_cycles >= 0) check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cycles));
        check({tag, "_words_out"}, 32'(rx_count), 32'(total));
        check({tag, "_reads"}, 32'(reads_seen), 32'(total));
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] neg_words [4];
        int          wait_cyc;
        neg_words = '{32'hC000_0000, 32'h4060_0000, 32'h8000_0000, 32'hFFC0_0000};
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        mem[0] = 32'h3F80_0000; mem[1] = 32'h4000_0000; mem[2] = 32'h4040_0000;
        mem[3] = 32'h4080_0000; mem[4] = 32'h40A0_0000; mem[5] = 32'h40C0_0000;
        for (int i = 0; i < 4; i++) mem[32 + i] = neg_words[i];
        mem[16'hFFFE] = 32'hDEAD_0001;
        mem[16'hFFFF] = 32'hBEEF_0002;
        for (int i = 0; i < 16; i++) mem[100 + i] = (i % 3 == 0) ? (32'h8000_0100 + 32'(i)) : (32'h1234_0000 + 32'(i));

        reset_n = 1'b0; start_valid = 1'b0; out_ready = 1'b1;
        num_rows = '0; num_cols = '0; base_addr = '0; relu_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        run_drain("basic_2x3", 2, 3, 16'h0000, 1'b0, 1'b0, 8);
        run_drain("stall_2x3", 2, 3, 16'h0000, 1'b0, 1'b1, -1);
        run_drain("relu_1x4", 1, 4, 16'd32, 1'b1, 1'b0, 6);
        run_drain("zero_rows", 0, 5, 16'h0000, 1'b0, 1'b0, 0);
        run_drain("zero_cols", 3, 0, 16'h0000, 1'b0, 1'b0, 0);

        run_drain("wrap_1x4", 1, 4, 16'hFFFE, 1'b0, 1'b0, 6);
        check("wrap_addr_count", 32'(rd_addrs.size()), 32'd4);
        if (rd_addrs.size() == 4) begin
            check("wrap_addr0", 32'(rd_addrs[0]), 32'h0000_FFFE);
            check("wrap_addr1", 32'(rd_addrs[1]), 32'h0000_FFFF);
            check("wrap_addr2", 32'(rd_addrs[2]), 32'h0000_0000);
            check("wrap_addr3", 32'(rd_addrs[3]), 32'h0000_0001);
        end

        // Reset partway through a 4x4 drain, then a full clean drain.
        push_expect(4, 4, 16'd100, 1'b0);
        do_start(4, 4, 16'd100, 1'b0);
        wait_cyc = 0;
        while (rx_count < 3 && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("midreset_3_words", 32'(rx_count >= 3), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_no_output", 32'(out_valid), 32'd0);
        check("midreset_no_done", 32'(done), 32'd0);
        run_drain("after_reset_4x4", 4, 4, 16'd100, 1'b0, 1'b0, 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
